// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD up/down counter: digit width, FSM states
// and a decimal-to-packed-BCD helper used for the upper-limit compare.
package bcd_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LOCKOUT = 1'b1
  } state_e;

  function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int value);
    logic [BCD_W*MAX_DIGITS-1:0] res;
    int v;
    res = '0;
    v   = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      res[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit (0-9) with increment/decrement enables and
// ripple carry/borrow links to its neighbours.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             inc_en,
  input  logic             dec_en,
  input  logic             carry_in,
  input  logic             borrow_in,
  output logic             carry_out,
  output logic             borrow_out,
  output logic [BCD_W-1:0] digit_d,
  output logic [BCD_W-1:0] digit_q
);

  // A digit only steps when the ripple reaches it; it wraps 9<->0 and passes the carry/borrow on.
  always_comb begin
    carry_out  = carry_in && (digit_q == 4'd9);
    borrow_out = borrow_in && (digit_q == 4'd0);
    digit_d    = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = load_val;
    end else if (inc_en && carry_in) begin
      digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (dec_en && borrow_in) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter fed by single-cycle button pulses, with a
// post-event lockout window, wrap/saturate limits and registered boundary flags.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int MAX_VALUE      = 9999,
  parameter int WRAP_EN        = 1,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                    new_clk,
  input  logic                    rst_n,
  input  logic                    inc_pulse,
  input  logic                    dec_pulse,
  input  logic                    clear,
  output logic [BCD_W*DIGITS-1:0] bcd_value,
  output logic                    at_zero,
  output logic                    at_max,
  output logic                    wrap_evt,
  output logic                    busy
);

  localparam int VAL_W = BCD_W * DIGITS;
  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [BCD_W*MAX_DIGITS-1:0] MAX_BCD_FULL = to_bcd(MAX_VALUE);
  localparam logic [VAL_W-1:0] MAX_BCD   = MAX_BCD_FULL[VAL_W-1:0];
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_chk_digits
    $error("bcd_updown_counter: DIGITS must be between 1 and %0d", MAX_DIGITS);
  end
  if (MAX_VALUE <= 0 || MAX_VALUE >= 10 ** DIGITS) begin : g_chk_max
    $error("bcd_updown_counter: MAX_VALUE must be in 1 .. 10**DIGITS-1");
  end
  if (LOCKOUT_CYCLES < 1) begin : g_chk_lock
    $error("bcd_updown_counter: LOCKOUT_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             at_zero_q, at_zero_d;
  logic             at_max_q, at_max_d;
  logic             wrap_evt_q, wrap_evt_d;
  logic             busy_q, busy_d;

  logic             do_inc, do_dec, do_load;
  logic [VAL_W-1:0] load_val;
  logic [VAL_W-1:0] value_d, value_q;
  logic [DIGITS:0]  carry, borrow;
  logic             unused_chain;

  // Limit handling uses the registered flags, so the boundary decision never waits on the ripple chain.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    wrap_evt_d = 1'b0;
    do_inc     = 1'b0;
    do_dec     = 1'b0;
    do_load    = 1'b0;
    load_val   = '0;
    if (clear) begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inc_pulse ^ dec_pulse) begin
            state_d    = LOCKOUT;
            lock_cnt_d = LOCK_LOAD;
            if (inc_pulse) begin
              if (at_max_q) begin
                wrap_evt_d = 1'b1;
                do_load    = (WRAP_EN != 0);
                load_val   = '0;
              end else begin
                do_inc = 1'b1;
              end
            end else begin
              if (at_zero_q) begin
                wrap_evt_d = 1'b1;
                do_load    = (WRAP_EN != 0);
                load_val   = MAX_BCD;
              end else begin
                do_dec = 1'b1;
              end
            end
          end
        end
        LOCKOUT: begin
          if (lock_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            lock_cnt_d = lock_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    at_zero_d = (value_d == '0);
    at_max_d  = (value_d == MAX_BCD);
    busy_d    = (state_d == LOCKOUT);
  end

  assign carry[0]     = 1'b1;
  assign borrow[0]    = 1'b1;
  assign unused_chain = ^{carry[DIGITS], borrow[DIGITS]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (new_clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .load       (do_load),
      .load_val   (load_val[g*BCD_W +: BCD_W]),
      .inc_en     (do_inc),
      .dec_en     (do_dec),
      .carry_in   (carry[g]),
      .borrow_in  (borrow[g]),
      .carry_out  (carry[g+1]),
      .borrow_out (borrow[g+1]),
      .digit_d    (value_d[g*BCD_W +: BCD_W]),
      .digit_q    (value_q[g*BCD_W +: BCD_W])
    );
  end

  always_ff @(posedge new_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      at_zero_q  <= 1'b1;
      at_max_q   <= 1'b0;
      wrap_evt_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      at_zero_q  <= at_zero_d;
      at_max_q   <= at_max_d;
      wrap_evt_q <= wrap_evt_d;
      busy_q     <= busy_d;
    end
  end

  assign bcd_value = value_q;
  assign at_zero   = at_zero_q;
  assign at_max    = at_max_q;
  assign wrap_evt  = wrap_evt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: three instances (default, wrap with short
// lockout, saturate with short lockout) checked against an integer reference model.
module tb_bcd_updown_counter;

  localparam int NI   = 3;
  localparam int MAXV = 9999;

  logic        new_clk = 1'b0;
  logic        rst_n;
  logic        inc_p [NI];
  logic        dec_p [NI];
  logic        clr_p [NI];
  logic [15:0] val   [NI];
  logic        az    [NI];
  logic        am    [NI];
  logic        we    [NI];
  logic        bz    [NI];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          inst;
    string       tag;
    logic [15:0] v;
    logic        az;
    logic        am;
    logic        we;
    logic        b;
  } exp_t;

  exp_t sb[$];

  int m_count [NI];
  int m_lock  [NI];
  bit m_wrap  [NI];

  always #5 new_clk = ~new_clk;

  bcd_updown_counter dut (
    .new_clk(new_clk), .rst_n(rst_n), .inc_pulse(inc_p[0]), .dec_pulse(dec_p[0]),
    .clear(clr_p[0]), .bcd_value(val[0]), .at_zero(az[0]), .at_max(am[0]),
    .wrap_evt(we[0]), .busy(bz[0])
  );

  bcd_updown_counter #(.WRAP_EN(1), .LOCKOUT_CYCLES(1)) dut_fast (
    .new_clk(new_clk), .rst_n(rst_n), .inc_pulse(inc_p[1]), .dec_pulse(dec_p[1]),
    .clear(clr_p[1]), .bcd_value(val[1]), .at_zero(az[1]), .at_max(am[1]),
    .wrap_evt(we[1]), .busy(bz[1])
  );

  bcd_updown_counter #(.WRAP_EN(0), .LOCKOUT_CYCLES(1)) dut_sat (
    .new_clk(new_clk), .rst_n(rst_n), .inc_pulse(inc_p[2]), .dec_pulse(dec_p[2]),
    .clear(clr_p[2]), .bcd_value(val[2]), .at_zero(az[2]), .at_max(am[2]),
    .wrap_evt(we[2]), .busy(bz[2])
  );

  function automatic int lockOf(int i);
    return (i == 0) ? 16 : 1;
  endfunction

  function automatic bit wrapOf(int i);
    return (i != 2);
  endfunction

  function automatic logic [15:0] toBcd16(int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NI; k++) begin
      m_count[k] = 0;
      m_lock[k]  = 0;
      m_wrap[k]  = 1'b0;
    end
  endtask

  // m_lock counts remaining busy cycles; a pulse is only taken when it is already zero.
  task automatic modelStep(int i, bit inc, bit dec, bit clr);
    if (clr) begin
      m_count[i] = 0;
      m_lock[i]  = 0;
      m_wrap[i]  = 1'b0;
    end else if (m_lock[i] > 0) begin
      m_lock[i]--;
      m_wrap[i] = 1'b0;
    end else if (inc && !dec) begin
      m_lock[i] = lockOf(i);
      m_wrap[i] = (m_count[i] == MAXV);
      if (m_count[i] == MAXV) m_count[i] = wrapOf(i) ? 0 : MAXV;
      else m_count[i]++;
    end else if (dec && !inc) begin
      m_lock[i] = lockOf(i);
      m_wrap[i] = (m_count[i] == 0);
      if (m_count[i] == 0) m_count[i] = wrapOf(i) ? MAXV : 0;
      else m_count[i]--;
    end else begin
      m_wrap[i] = 1'b0;
    end
  endtask

  task automatic pushExp(int i, string tag);
    exp_t e;
    e.inst = i;
    e.tag  = tag;
    e.v    = toBcd16(m_count[i]);
    e.az   = (m_count[i] == 0);
    e.am   = (m_count[i] == MAXV);
    e.we   = m_wrap[i];
    e.b    = (m_lock[i] > 0);
    sb.push_back(e);
  endtask

  task automatic checkField(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkField({e.tag, ".value"},    val[e.inst],          e.v);
      checkField({e.tag, ".at_zero"},  16'(az[e.inst]),      16'(e.az));
      checkField({e.tag, ".at_max"},   16'(am[e.inst]),      16'(e.am));
      checkField({e.tag, ".wrap_evt"}, 16'(we[e.inst]),      16'(e.we));
      checkField({e.tag, ".busy"},     16'(bz[e.inst]),      16'(e.b));
    end
  endtask

  task automatic clearInputs();
    for (int k = 0; k < NI; k++) begin
      inc_p[k] = 1'b0;
      dec_p[k] = 1'b0;
      clr_p[k] = 1'b0;
    end
  endtask

  // One clock cycle: drive instance i, step every model, then compare after the edge.
  task automatic applyStimulus(int i, bit inc, bit dec, bit clr, string tag, bit chk);
    @(negedge new_clk);
    clearInputs();
    inc_p[i] = inc;
    dec_p[i] = dec;
    clr_p[i] = clr;
    for (int k = 0; k < NI; k++) begin
      if (k == i) modelStep(k, inc, dec, clr);
      else modelStep(k, 1'b0, 1'b0, 1'b0);
    end
    if (chk) pushExp(i, tag);
    @(posedge new_clk);
    #1;
    if (chk) checkOutput();
  endtask

  task automatic idleCycles(int i, int n, string tag);
    for (int c = 0; c < n; c++) applyStimulus(i, 1'b0, 1'b0, 1'b0, tag, 1'b1);
  endtask

  task automatic rampUp(int i, int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(i, 1'b1, 1'b0, 1'b0, "", 1'b0);
      for (int w = 0; w < lockOf(i); w++) applyStimulus(i, 1'b0, 1'b0, 1'b0, "", 1'b0);
    end
  endtask

  // Reset is asserted between clock edges and checked before any edge arrives.
  task automatic doReset(string tag);
    @(negedge new_clk);
    clearInputs();
    rst_n = 1'b0;
    modelReset();
    #1;
    for (int k = 0; k < NI; k++) begin
      pushExp(k, $sformatf("%s%0d", tag, k));
      checkOutput();
    end
    @(posedge new_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    rst_n = 1'b1;
    clearInputs();
    modelReset();
    doReset("reset");

    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, 1'b1, 1'b0, 1'b0, $sformatf("three.inc%0d", p), 1'b1);
      idleCycles(0, 19, "three.gap");
    end
    checkField("three.value", val[0], 16'h0003);
    checkField("three.at_zero", 16'(az[0]), 16'h0000);

    applyStimulus(0, 1'b1, 1'b0, 1'b0, "lock.accept", 1'b1);
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(0, (k == 1 || k == 8 || k == 15 || k == 16 || k == 17), 1'b0, 1'b0,
                    $sformatf("lock.c%0d", k), 1'b1);
    end
    checkField("lock.value", val[0], 16'h0005);
    idleCycles(0, 17, "lock.drain");

    applyStimulus(0, 1'b1, 1'b1, 1'b0, "both", 1'b1);
    checkField("both.busy", 16'(bz[0]), 16'h0000);

    applyStimulus(0, 1'b1, 1'b0, 1'b0, "clr.inc", 1'b1);
    idleCycles(0, 3, "clr.wait");
    applyStimulus(0, 1'b0, 1'b0, 1'b1, "clr.clear", 1'b1);
    checkField("clr.value", val[0], 16'h0000);
    checkField("clr.busy", 16'(bz[0]), 16'h0000);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, "clr.after", 1'b1);
    idleCycles(0, 16, "clr.drain");

    applyStimulus(0, 1'b0, 1'b1, 1'b0, "wrap.to0", 1'b1);
    idleCycles(0, 16, "wrap.d0");
    applyStimulus(0, 1'b0, 1'b1, 1'b0, "wrap.dec", 1'b1);
    checkField("wrap.dec.value", val[0], 16'h9999);
    checkField("wrap.dec.at_max", 16'(am[0]), 16'h0001);
    idleCycles(0, 16, "wrap.d1");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, "wrap.inc", 1'b1);
    checkField("wrap.inc.value", val[0], 16'h0000);
    checkField("wrap.inc.at_zero", 16'(az[0]), 16'h0001);
    idleCycles(0, 16, "wrap.d2");

    applyStimulus(0, 1'b1, 1'b0, 1'b0, "rmid.inc", 1'b1);
    idleCycles(0, 5, "rmid.wait");
    doReset("rmid");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, "rmid.first", 1'b1);
    idleCycles(0, 16, "rmid.drain");

    rampUp(1, 9);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, "fast.carry", 1'b1);
    checkField("fast.carry.value", val[1], 16'h0010);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, "fast.carry.lock", 1'b1);
    rampUp(1, 990);
    checkField("fast.preload", val[1], 16'h1000);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, "fast.borrow", 1'b1);
    checkField("fast.borrow.value", val[1], 16'h0999);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, "fast.borrow.lock", 1'b1);

    applyStimulus(2, 1'b0, 1'b1, 1'b0, "sat.dec0", 1'b1);
    checkField("sat.dec0.wrap_evt", 16'(we[2]), 16'h0001);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, "sat.dec0.next", 1'b1);
    rampUp(2, 9999);
    checkField("sat.full.at_max", 16'(am[2]), 16'h0001);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, "sat.inc", 1'b1);
    checkField("sat.inc.value", val[2], 16'h9999);
    checkField("sat.inc.busy", 16'(bz[2]), 16'h0001);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, "sat.inc.next", 1'b1);

    clearInputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
